pong_ball_engine: RTL and testbench
===================================

PONG_BALL_ENGINE -- requirements
Module: pong_ball_engine

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 60, motion update rate in Hz.
REQ-003 Parameter PADDLE_STEP, default 4, paddle pixels moved per tick.
REQ-004 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-low.
REQ-006 Port stop  input  1  high = game not in play, driven by the top-level game FSM.
REQ-007 Ports up1, down1, up2, down2  input  1 each  paddle commands from the keypad controller, level-sensitive.
REQ-008 Port ball_x  output  10  ball left edge in pixels, range 0..632.
REQ-009 Port ball_y  output  10  ball top edge in pixels, range 0..472.
REQ-010 Ports paddle1_q, paddle2_q  output  9 each  paddle top edge in pixels, range 0..416.
REQ-011 Ports miss1, miss2  output  1 each  one-clk pulse: the left (miss1) or right (miss2) player conceded.

Function
REQ-012 Geometry SHALL be: field 640x480; ball 8x8; paddles 8 wide and 64 tall; paddle1 at x 16..23; paddle2 at x 616..623.
REQ-013 A tick SHALL be a one-clk strobe every CLK_HZ/TICK_HZ clks; all motion SHALL occur only on tick; registered outputs SHALL update on the clk after the tick.
REQ-014 States SHALL be SERVE, MOVE and MISS.
REQ-015 SERVE: ball held at (316,236); transition to MOVE on the first tick with stop=0.
REQ-016 MOVE with stop=1: ball frozen, no state change (pause).
REQ-017 MOVE with stop=0: on each tick, ball moves by speed in x and by 1 in y, in the current directions dx and dy.
REQ-018 MISS: ball frozen; on stop=1, ball recentres to (316,236) and the state goes to SERVE.
REQ-019 Paddles SHALL move by PADDLE_STEP per tick in every state, with up decreasing y; the result SHALL be clamped to 0..416.
REQ-020 If up and down for the same paddle are both high, that paddle SHALL hold its position.
REQ-021 Wall bounce: if the computed y is <=0, y SHALL be set to 0 and dy set to down; if it is >=472, y SHALL be set to 472 and dy set to up.
REQ-022 Left paddle hit: moving left, computed x <=24, and ball_y+7 >= paddle1_q and ball_y <= paddle1_q+63 -> x set to 24, dx set to right, hit count +1.
REQ-023 Right paddle hit: mirror of REQ-022, using threshold 608 against paddle2_q.
REQ-024 Overlap tests SHALL use the pre-tick registered ball_y and paddle values.
REQ-025 Miss: no hit and computed x <=0 -> x=0, miss1 pulses one clk, state goes to MISS.
REQ-026 Miss: no hit and computed x >=632 -> x=632, miss2 pulses one clk, state goes to MISS.
REQ-027 Wall bounce and paddle hit or miss on the same tick SHALL both apply.
REQ-028 Speed SHALL be 1 + hit_count/4, saturating at 4.
REQ-029 hit_count SHALL be 4 bits and saturating, and SHALL clear on entry to SERVE.
REQ-030 Serve direction SHALL be: dx toward the player who conceded last, or right after reset; dy down.
REQ-031 miss1 and miss2 SHALL never be high simultaneously.
REQ-032 miss1 and miss2 SHALL not re-pulse while the state is MISS.

Reset
REQ-033 rst low SHALL immediately set: state SERVE; ball (316,236); paddles 208; dx right; dy down; hit_count 0; misses 0; tick divider 0.
REQ-034 Reset asserted mid-MOVE or mid-MISS SHALL abandon the rally without any miss pulse.

Structure
REQ-035 Field, ball, paddle and centre constants, plus the state encoding, SHALL live in the shared package pong_pkg.
REQ-036 The tick divider SHALL be the sub-module frame_tick (clk, rst, tick).
REQ-037 All outputs SHALL be registered.

Verification
REQ-038 Reset -> ball (316,236), paddles 208, miss1=miss2=0, state SERVE.
REQ-039 stop=0, no keys -> first MOVE tick gives ball (317,237); after 60 ticks ball_x=376.
REQ-040 Hold up1 for 60 ticks -> paddle1_q=0 and stays 0; up1+down1 together -> no change.
REQ-041 Ball at (25,100) moving left at speed 1, paddle1_q=80 -> x=24, dx right, hit_count=1.
REQ-042 Same case with paddle1_q=300 -> ball reaches x=0, miss1 one-clk pulse, state MISS; stop=1 -> SERVE, next serve moves left.
REQ-043 Eight consecutive paddle hits -> speed 3; stop held high in MOVE for 100 ticks -> ball position unchanged.

Source files
------------

// File: rtl/pong_ball_engine_pkg.sv
// Shared geometry constants, widths and state encoding for the pong ball engine.
package pong_pkg;

  localparam int unsigned FIELD_W      = 640;
  localparam int unsigned FIELD_H      = 480;
  localparam int unsigned BALL_SIZE    = 8;
  localparam int unsigned PADDLE_W     = 8;
  localparam int unsigned PADDLE_H     = 64;
  localparam int unsigned PADDLE1_X    = 16;
  localparam int unsigned PADDLE2_X    = 616;

  localparam int unsigned BALL_X_MAX   = FIELD_W - BALL_SIZE;
  localparam int unsigned BALL_Y_MAX   = FIELD_H - BALL_SIZE;
  localparam int unsigned PADDLE_Y_MAX = FIELD_H - PADDLE_H;
  localparam int unsigned CENTRE_X     = (FIELD_W - BALL_SIZE) / 2;
  localparam int unsigned CENTRE_Y     = (FIELD_H - BALL_SIZE) / 2;
  localparam int unsigned PADDLE_INIT  = (FIELD_H - PADDLE_H) / 2;
  localparam int unsigned HIT_LEFT_X   = PADDLE1_X + PADDLE_W;
  localparam int unsigned HIT_RIGHT_X  = PADDLE2_X - BALL_SIZE;

  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 10;
  localparam int unsigned P_W   = 9;
  localparam int unsigned HIT_W = 4;
  localparam int unsigned SPD_W = 3;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    MOVE  = 2'd1,
    MISS  = 2'd2
  } state_e;

  // One extra pixel per tick for every four hits; 15 hits gives the cap of 4.
  function automatic logic [SPD_W-1:0] speed_of(input logic [HIT_W-1:0] hits);
    return SPD_W'(1) + SPD_W'(hits[HIT_W-1:2]);
  endfunction

endpackage

// File: rtl/pong_ball_engine_frame_tick.sv
// Motion-rate divider: one-clk registered strobe every CLK_HZ/TICK_HZ clks.
module frame_tick #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 60
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned DIV = (CLK_HZ / TICK_HZ > 0) ? CLK_HZ / TICK_HZ : 1;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    tick_d = 1'b0;
    if (cnt_q == CW'(DIV - 1)) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/pong_ball_engine.sv
// Ball and paddle motion engine: serve/move/miss rally control with wall and paddle bounces.
module pong_ball_engine
  import pong_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned TICK_HZ     = 60,
  parameter int unsigned PADDLE_STEP = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stop,
  input  logic           up1,
  input  logic           down1,
  input  logic           up2,
  input  logic           down2,
  output logic [X_W-1:0] ball_x,
  output logic [Y_W-1:0] ball_y,
  output logic [P_W-1:0] paddle1_q,
  output logic [P_W-1:0] paddle2_q,
  output logic           miss1,
  output logic           miss2
);

  localparam int unsigned XW1 = X_W + 1;
  localparam int unsigned YW1 = Y_W + 1;
  localparam int unsigned PW1 = P_W + 1;

  logic             tick;
  state_e           state_q, state_d;
  logic [X_W-1:0]   ball_x_q, ball_x_d;
  logic [Y_W-1:0]   ball_y_q, ball_y_d;
  logic [P_W-1:0]   paddle1_d, paddle2_d;
  logic             dx_left_q, dx_left_d;
  logic             dy_up_q, dy_up_d;
  logic [HIT_W-1:0] hit_q, hit_d, hit_inc;
  logic             miss1_q, miss1_d, miss2_q, miss2_d;
  logic [SPD_W-1:0] speed;
  logic [XW1-1:0]   x_sum;
  logic             ov1, ov2, left_reach;

  frame_tick #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_frame_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Opposing commands cancel; travel is clamped to the field.
  function automatic logic [P_W-1:0] paddle_next(input logic [P_W-1:0] p,
                                                 input logic up, input logic dn);
    logic [PW1-1:0] sum;
    sum         = {1'b0, p} + PW1'(PADDLE_STEP);
    paddle_next = p;
    if (up && !dn) begin
      paddle_next = (p <= P_W'(PADDLE_STEP)) ? '0 : p - P_W'(PADDLE_STEP);
    end else if (dn && !up) begin
      paddle_next = (sum >= PW1'(PADDLE_Y_MAX)) ? P_W'(PADDLE_Y_MAX) : sum[P_W-1:0];
    end
  endfunction

  assign speed      = speed_of(hit_q);
  assign hit_inc    = (&hit_q) ? hit_q : hit_q + HIT_W'(1);
  assign x_sum      = {1'b0, ball_x_q} + XW1'(speed);
  assign left_reach = (ball_x_q <= X_W'(HIT_LEFT_X) + X_W'(speed));
  assign ov1 = ({1'b0, ball_y_q} + YW1'(BALL_SIZE - 1) >= YW1'(paddle1_q)) &&
               ({1'b0, ball_y_q} <= YW1'(paddle1_q) + YW1'(PADDLE_H - 1));
  assign ov2 = ({1'b0, ball_y_q} + YW1'(BALL_SIZE - 1) >= YW1'(paddle2_q)) &&
               ({1'b0, ball_y_q} <= YW1'(paddle2_q) + YW1'(PADDLE_H - 1));

  always_comb begin
    state_d   = state_q;
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    paddle1_d = paddle1_q;
    paddle2_d = paddle2_q;
    dx_left_d = dx_left_q;
    dy_up_d   = dy_up_q;
    hit_d     = hit_q;
    miss1_d   = 1'b0;
    miss2_d   = 1'b0;

    if (tick) begin
      paddle1_d = paddle_next(paddle1_q, up1, down1);
      paddle2_d = paddle_next(paddle2_q, up2, down2);

      case (state_q)
        SERVE: begin
          ball_x_d = X_W'(CENTRE_X);
          ball_y_d = Y_W'(CENTRE_Y);
          if (!stop) state_d = MOVE;
        end

        MOVE: begin
          if (!stop) begin
            if (dy_up_q) begin
              if (ball_y_q <= Y_W'(1)) begin
                ball_y_d = '0;
                dy_up_d  = 1'b0;
              end else begin
                ball_y_d = ball_y_q - Y_W'(1);
              end
            end else begin
              if (ball_y_q + Y_W'(1) >= Y_W'(BALL_Y_MAX)) begin
                ball_y_d = Y_W'(BALL_Y_MAX);
                dy_up_d  = 1'b1;
              end else begin
                ball_y_d = ball_y_q + Y_W'(1);
              end
            end

            // A paddle hit takes priority over a miss on the same tick.
            if (dx_left_q) begin
              if (left_reach && ov1) begin
                ball_x_d  = X_W'(HIT_LEFT_X);
                dx_left_d = 1'b0;
                hit_d     = hit_inc;
              end else if (ball_x_q <= X_W'(speed)) begin
                ball_x_d = '0;
                miss1_d  = 1'b1;
                state_d  = MISS;
              end else begin
                ball_x_d = ball_x_q - X_W'(speed);
              end
            end else begin
              if ((x_sum >= XW1'(HIT_RIGHT_X)) && ov2) begin
                ball_x_d  = X_W'(HIT_RIGHT_X);
                dx_left_d = 1'b1;
                hit_d     = hit_inc;
              end else if (x_sum >= XW1'(BALL_X_MAX)) begin
                ball_x_d = X_W'(BALL_X_MAX);
                miss2_d  = 1'b1;
                state_d  = MISS;
              end else begin
                ball_x_d = x_sum[X_W-1:0];
              end
            end
          end
        end

        MISS: begin
          // dx still points at the player who conceded, which is the serve direction.
          if (stop) begin
            state_d  = SERVE;
            ball_x_d = X_W'(CENTRE_X);
            ball_y_d = Y_W'(CENTRE_Y);
            dy_up_d  = 1'b0;
            hit_d    = '0;
          end
        end

        default: state_d = SERVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= SERVE;
      ball_x_q  <= X_W'(CENTRE_X);
      ball_y_q  <= Y_W'(CENTRE_Y);
      paddle1_q <= P_W'(PADDLE_INIT);
      paddle2_q <= P_W'(PADDLE_INIT);
      dx_left_q <= 1'b0;
      dy_up_q   <= 1'b0;
      hit_q     <= '0;
      miss1_q   <= 1'b0;
      miss2_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      paddle1_q <= paddle1_d;
      paddle2_q <= paddle2_d;
      dx_left_q <= dx_left_d;
      dy_up_q   <= dy_up_d;
      hit_q     <= hit_d;
      miss1_q   <= miss1_d;
      miss2_q   <= miss2_d;
    end
  end

  assign ball_x = ball_x_q;
  assign ball_y = ball_y_q;
  assign miss1  = miss1_q;
  assign miss2  = miss2_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Randomized bench for pong_ball_engine against a rule-level rally model.
module tb_pong_ball_engine;

  localparam int CLK_HZ  = 40;
  localparam int TICK_HZ = 10;
  localparam int STEP    = 4;
  localparam int DIV     = CLK_HZ / TICK_HZ;

  localparam int PH_SERVE = 0;
  localparam int PH_RALLY = 1;
  localparam int PH_DEAD  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stop = 1'b1;
  logic       up1 = 1'b0, down1 = 1'b0, up2 = 1'b0, down2 = 1'b0;
  logic [9:0] ball_x, ball_y;
  logic [8:0] paddle1_q, paddle2_q;
  logic       miss1, miss2;

  always #5 clk = ~clk;

  pong_ball_engine #(
    .CLK_HZ     (CLK_HZ),
    .TICK_HZ    (TICK_HZ),
    .PADDLE_STEP(STEP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .stop     (stop),
    .up1      (up1),
    .down1    (down1),
    .up2      (up2),
    .down2    (down2),
    .ball_x   (ball_x),
    .ball_y   (ball_y),
    .paddle1_q(paddle1_q),
    .paddle2_q(paddle2_q),
    .miss1    (miss1),
    .miss2    (miss2)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: field coordinates as plain integers, clocks counted since reset.
  int e, m_x, m_y, m_p1, m_p2, m_hit, m_phase;
  bit m_right, m_down, m_miss1, m_miss2;
  bit trk1 = 1'b0, trk2 = 1'b0;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int pmove(input int p, input bit u, input bit d);
    if (u && !d) return clampi(p - STEP, 0, 416);
    if (d && !u) return clampi(p + STEP, 0, 416);
    return p;
  endfunction

  task automatic model_reset();
    e = 0; m_x = 316; m_y = 236; m_p1 = 208; m_p2 = 208;
    m_right = 1'b1; m_down = 1'b1; m_hit = 0; m_phase = PH_SERVE;
    m_miss1 = 1'b0; m_miss2 = 1'b0;
  endtask

  task automatic model_edge();
    int spd, nx, ny, p1o, p2o;
    bit ov1, ov2;
    if (!rst) return;
    e++;
    m_miss1 = 1'b0;
    m_miss2 = 1'b0;
    if (e <= DIV || (e - 1) % DIV != 0) return;
    p1o  = m_p1;
    p2o  = m_p2;
    m_p1 = pmove(m_p1, up1, down1);
    m_p2 = pmove(m_p2, up2, down2);
    if (m_phase == PH_SERVE) begin
      m_x = 316; m_y = 236;
      if (!stop) m_phase = PH_RALLY;
    end else if (m_phase == PH_RALLY) begin
      if (!stop) begin
        spd = (1 + m_hit / 4 > 4) ? 4 : 1 + m_hit / 4;
        nx  = m_right ? m_x + spd : m_x - spd;
        ny  = m_down ? m_y + 1 : m_y - 1;
        if (ny <= 0) begin ny = 0; m_down = 1'b1; end
        else if (ny >= 472) begin ny = 472; m_down = 1'b0; end
        ov1 = (m_y + 7 >= p1o) && (m_y <= p1o + 63);
        ov2 = (m_y + 7 >= p2o) && (m_y <= p2o + 63);
        if (!m_right && nx <= 24 && ov1) begin
          nx = 24; m_right = 1'b1; m_hit = (m_hit < 15) ? m_hit + 1 : 15;
        end else if (m_right && nx >= 608 && ov2) begin
          nx = 608; m_right = 1'b0; m_hit = (m_hit < 15) ? m_hit + 1 : 15;
        end else if (nx <= 0) begin
          nx = 0; m_miss1 = 1'b1; m_phase = PH_DEAD;
        end else if (nx >= 632) begin
          nx = 632; m_miss2 = 1'b1; m_phase = PH_DEAD;
        end
        m_x = nx;
        m_y = ny;
      end
    end else begin
      if (stop) begin
        m_phase = PH_SERVE; m_x = 316; m_y = 236; m_hit = 0; m_down = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check("ball_x", int'(ball_x), m_x);
    check("ball_y", int'(ball_y), m_y);
    check("paddle1", int'(paddle1_q), m_p1);
    check("paddle2", int'(paddle2_q), m_p2);
    check("miss1", int'(miss1), int'(m_miss1));
    check("miss2", int'(miss2), int'(m_miss2));
    check("miss_excl", int'(miss1 && miss2), 0);
  endtask

  // Keep a paddle centred on the ball as a competent player would.
  task automatic drive_track();
    if (trk1) begin
      up1   = (int'(paddle1_q) + 28 > int'(ball_y) + 2);
      down1 = (int'(paddle1_q) + 30 < int'(ball_y));
    end
    if (trk2) begin
      up2   = (int'(paddle2_q) + 28 > int'(ball_y) + 2);
      down2 = (int'(paddle2_q) + 30 < int'(ball_y));
    end
  endtask

  task automatic cycle();
    drive_track();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_ticks(input int n);
    cycles(n * DIV);
  endtask

  task automatic keys(input bit a, input bit b, input bit c, input bit d);
    up1 = a; down1 = b; up2 = c; down2 = d;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_x"}, int'(ball_x), 316);
    check({tag, "_y"}, int'(ball_y), 236);
    check({tag, "_p1"}, int'(paddle1_q), 208);
    check({tag, "_p2"}, int'(paddle2_q), 208);
    check({tag, "_m1"}, int'(miss1), 0);
    check({tag, "_m2"}, int'(miss2), 0);
  endtask

  // Asserted mid-cycle to exercise the asynchronous path; released aligned to ticks.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    check_reset_values(tag);
    model_reset();
    cycles(2);
    rst = 1'b1;
    cycle();
  endtask

  initial begin
    int sx, sy, dx;
    bit seen;
    model_reset();
    #2;
    do_reset("rst0");

    // Serve and free flight.
    stop = 1'b0;
    keys(0, 0, 0, 0);
    run_ticks(1);
    check("serve_hold_x", int'(ball_x), 316);
    run_ticks(1);
    check("first_move_x", int'(ball_x), 317);
    check("first_move_y", int'(ball_y), 237);
    run_ticks(59);
    check("move60_x", int'(ball_x), 376);

    // Paddle clamp and opposing keys.
    keys(1, 0, 0, 0);
    run_ticks(60);
    check("p1_clamp_top", int'(paddle1_q), 0);
    keys(1, 1, 0, 0);
    run_ticks(10);
    check("p1_both_hold", int'(paddle1_q), 0);
    check("p2_idle", int'(paddle2_q), 208);

    // Reset in the middle of a rally.
    keys(0, 0, 0, 0);
    do_reset("rst_mid");

    // Left player parks low and concedes; right player returns the serve.
    stop = 1'b0;
    keys(0, 1, 0, 0);
    trk2 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10000 && !seen; i++) begin
      cycle();
      if (m_miss1) seen = 1'b1;
    end
    check("miss1_seen", int'(miss1), 1);
    trk2 = 1'b0;
    keys(0, 0, 0, 0);
    cycle();
    check("miss1_width", int'(miss1), 0);
    cycles(DIV - 1);
    run_ticks(3);
    check("miss_frozen_x", int'(ball_x), 0);
    stop = 1'b1;
    run_ticks(1);
    check("reserve_x", int'(ball_x), 316);
    stop = 1'b0;
    run_ticks(2);
    check("serve_left_x", int'(ball_x), 315);
    check("serve_left_y", int'(ball_y), 237);

    // Long rally until eight hits, then the ball should travel 3 px per tick.
    trk1 = 1'b1;
    trk2 = 1'b1;
    for (int i = 0; i < 40000 && m_hit < 8; i++) cycle();
    if (m_hit < 8) check("hit8_timeout", m_hit, 8);
    sx = m_x;
    run_ticks(1);
    dx = int'(ball_x) - sx;
    check("speed3_dx", (dx < 0) ? -dx : dx, 3);

    // Pause in play.
    trk1 = 1'b0;
    trk2 = 1'b0;
    keys(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
    stop = 1'b1;
    sx = m_x;
    sy = m_y;
    run_ticks(100);
    check("pause_x", int'(ball_x), sx);
    check("pause_y", int'(ball_y), sy);

    // Random play in mixed modes.
    for (int seg = 0; seg < 15; seg++) begin
      int mode;
      mode = int'($urandom % 3);
      trk1 = (mode == 1);
      trk2 = (mode == 1);
      for (int i = 0; i < 200; i++) begin
        keys(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
        if (mode == 0) stop = ($urandom % 8 == 0);
        else if (mode == 1) stop = ($urandom % 32 == 0);
        else stop = 1'($urandom % 2);
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
